// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: FSM states, redirect priority
// levels, stall-vector encodings and bus-level constants.
package fetch_ctrl_pkg;

  localparam int REG_BUS_W = 32;

  localparam logic BRANCH_ENABLE = 1'b1;
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_PEND  = 2'd1,
    FC_FLUSH = 2'd2
  } fc_state_t;

  // Numeric order is the arbitration order: a larger code wins.
  typedef enum logic [1:0] {
    PRI_NONE = 2'd0,
    PRI_BR   = 2'd1,
    PRI_MRET = 2'd2,
    PRI_TRAP = 2'd3
  } fc_pri_t;

  localparam logic [2:0] STALL_NONE = 3'b000;
  localparam logic [2:0] STALL_IF   = 3'b001;
  localparam logic [2:0] STALL_ID   = 3'b011;
  localparam logic [2:0] STALL_EX   = 3'b111;

  // A stall in a later stage must also hold every earlier register.
  function automatic logic [2:0] merge_stall(input logic req_if, input logic req_id,
                                             input logic req_ex);
    if (req_ex)      return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Front-end control bus between the pipeline stages and fetch_ctrl.
// master: stage side (raises stall/redirect requests, consumes stall/flush).
// slave:  fetch_ctrl.
interface fetch_ctrl_if import fetch_ctrl_pkg::*; #(
  parameter int ADDR_W = REG_BUS_W
) ();

  logic              stallreq_if_i;
  logic              stallreq_id_i;
  logic              stallreq_ex_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_addr_i;
  logic              trap_flag_i;
  logic [ADDR_W-1:0] trap_addr_i;
  logic              mret_flag_i;
  logic [ADDR_W-1:0] mret_addr_i;
  logic [2:0]        stalled_o;
  logic              branch_flag_o;
  logic [ADDR_W-1:0] branch_addr_o;
  logic              flush_o;
  logic              busy_o;

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i,
    output branch_flag_i, branch_addr_i, trap_flag_i, trap_addr_i,
    output mret_flag_i, mret_addr_i,
    input  stalled_o, branch_flag_o, branch_addr_o, flush_o, busy_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i,
    input  branch_flag_i, branch_addr_i, trap_flag_i, trap_addr_i,
    input  mret_flag_i, mret_addr_i,
    output stalled_o, branch_flag_o, branch_addr_o, flush_o, busy_o
  );

endinterface

// File: rtl/fetch_ctrl_redirect_arb.sv
// Fixed-priority redirect arbiter: trap > mret > branch. Purely combinational.
module fetch_ctrl_redirect_arb import fetch_ctrl_pkg::*; #(
  parameter int ADDR_W = REG_BUS_W
) (
  input  logic              trap_flag,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic              mret_flag,
  input  logic [ADDR_W-1:0] mret_addr,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              req_vld,
  output fc_pri_t           req_lvl,
  output logic [ADDR_W-1:0] req_addr
);

  // Pick the highest-priority active redirect source.
  always_comb begin
    req_vld  = 1'b0;
    req_lvl  = PRI_NONE;
    req_addr = '0;
    if (trap_flag) begin
      req_vld  = 1'b1;
      req_lvl  = PRI_TRAP;
      req_addr = trap_addr;
    end else if (mret_flag) begin
      req_vld  = 1'b1;
      req_lvl  = PRI_MRET;
      req_addr = mret_addr;
    end else if (branch_flag) begin
      req_vld  = 1'b1;
      req_lvl  = PRI_BR;
      req_addr = branch_addr;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: merges stage stall requests, arbitrates PC redirects,
// holds a redirect that arrives while the PC is stalled, and squashes the
// wrong path with a FLUSH_CYCLES-long flush after each redirect.
// Optional build macro FETCH_CTRL_PERF_EN adds stall/redirect counters.
module fetch_ctrl import fetch_ctrl_pkg::*; #(
  parameter int ADDR_W       = REG_BUS_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  fetch_ctrl_if.slave bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_redir_cnt_o
`endif
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  fc_state_t         state;
  fc_pri_t           pend_lvl;
  logic [ADDR_W-1:0] pend_addr;
  logic [2:0]        flush_cnt;

  logic              req_vld;
  fc_pri_t           req_lvl;
  logic [ADDR_W-1:0] req_addr;
  logic              req_higher;
  logic              trap_req;
  logic [2:0]        base_stall;
  logic [2:0]        stalled;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;

  fetch_ctrl_redirect_arb #(.ADDR_W(ADDR_W)) u_arb (
    .trap_flag   (bus.trap_flag_i),
    .trap_addr   (bus.trap_addr_i),
    .mret_flag   (bus.mret_flag_i),
    .mret_addr   (bus.mret_addr_i),
    .branch_flag (bus.branch_flag_i),
    .branch_addr (bus.branch_addr_i),
    .req_vld     (req_vld),
    .req_lvl     (req_lvl),
    .req_addr    (req_addr)
  );

  assign base_stall = merge_stall(bus.stallreq_if_i, bus.stallreq_id_i, bus.stallreq_ex_i);
  assign req_higher = req_vld && (req_lvl > pend_lvl);
  assign trap_req   = req_vld && (req_lvl == PRI_TRAP);

  // Decide whether a redirect issues this cycle and build the stall vector;
  // the PC samples on negedge, so the redirect is visible with zero latency.
  always_comb begin
    issue      = 1'b0;
    issue_addr = '0;
    unique case (state)
      FC_IDLE: begin
        if (req_vld && base_stall[0] == NO_STOP) begin
          issue      = BRANCH_ENABLE;
          issue_addr = req_addr;
        end
      end
      FC_PEND: begin
        if (base_stall[0] == NO_STOP) begin
          issue      = BRANCH_ENABLE;
          issue_addr = req_higher ? req_addr : pend_addr;
        end
      end
      FC_FLUSH: begin
        // Only a trap survives a flush; branch/mret come from squashed slots.
        if (trap_req && base_stall[0] == NO_STOP) begin
          issue      = BRANCH_ENABLE;
          issue_addr = req_addr;
        end
      end
      default: ;
    endcase
    stalled = base_stall;
    if (state == FC_PEND && !issue) stalled = base_stall | STALL_IF;
    if (rst) begin
      issue      = 1'b0;
      issue_addr = '0;
      stalled    = STALL_NONE;
    end
  end

  assign bus.stalled_o     = stalled;
  assign bus.branch_flag_o = issue;
  assign bus.branch_addr_o = issue_addr;
  assign bus.flush_o       = !rst && (state == FC_FLUSH);
  assign bus.busy_o        = !rst && (state != FC_IDLE);

  // Redirect sequencing FSM with pending-redirect register and flush counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FC_IDLE;
      pend_lvl  <= PRI_NONE;
      pend_addr <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        FC_IDLE: begin
          if (issue) begin
            state     <= FC_FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end else if (req_vld) begin
            state     <= FC_PEND;
            pend_lvl  <= req_lvl;
            pend_addr <= req_addr;
          end
        end
        FC_PEND: begin
          if (issue) begin
            state     <= FC_FLUSH;
            flush_cnt <= FLUSH_LOAD;
            pend_lvl  <= PRI_NONE;
          end else if (req_higher) begin
            pend_lvl  <= req_lvl;
            pend_addr <= req_addr;
          end
        end
        FC_FLUSH: begin
          if (issue) begin
            flush_cnt <= FLUSH_LOAD;
          end else if (trap_req) begin
            state     <= FC_PEND;
            pend_lvl  <= req_lvl;
            pend_addr <= req_addr;
            flush_cnt <= '0;
          end else if (base_stall[2] != STOP) begin
            if (flush_cnt <= 3'd1) state <= FC_IDLE;
            else                   flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: state <= FC_IDLE;
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  // Free-running stall-cycle and redirect counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_o <= '0;
      perf_redir_cnt_o <= '0;
    end else begin
      if (stalled[0]) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (issue)      perf_redir_cnt_o <= perf_redir_cnt_o + 32'd1;
    end
  end
`endif

endmodule
